// File: rtl/divider_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : divider_sequencer
//  Purpose  : Control FSM for an 8-slice restoring divider built from
//             bitslice cells. It drives the shared per-slice control lines
//             to run one unsigned divide per Start request. It samples the
//             MSB-slice borrow and a divisor-zero flag, and reports
//             Busy/Done/DivZero to the host. The block holds no datapath
//             storage.
//  Ports    : clk_i           - system clock, rising edge
//             rst_i           - asynchronous active-high reset
//             start_i         - divide request, sampled only in IDLE
//             scan_enable_i   - freezes the FSM, drives test_o
//             n_borrow_out_i  - MSB-slice borrow (active-low) of trial subtract
//             divisor_zero_i  - high when the B register is all zero
//             busy_o          - high from LOAD through RESULT
//             done_o          - one-cycle completion pulse
//             div_zero_o      - one-cycle error pulse, coincident with done_o
//             load_a_o, load_b_o, load_m_o, load_result_o,
//             enable_op1_o, enable_op2_o, enable_sub_o, enable_zero_o,
//             increment_o, test_o - per-slice control lines
//             n_borrow_in_o   - borrow into the LSB slice (held inactive)
//  Revision : 1.0 - initial release
// ============================================================================
module divider_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic scan_enable_i,
    input  logic n_borrow_out_i,
    input  logic divisor_zero_i,
    output logic busy_o,
    output logic done_o,
    output logic div_zero_o,
    output logic load_a_o,
    output logic load_b_o,
    output logic load_m_o,
    output logic load_result_o,
    output logic enable_op1_o,
    output logic enable_op2_o,
    output logic enable_sub_o,
    output logic enable_zero_o,
    output logic increment_o,
    output logic n_borrow_in_o,
    output logic test_o
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD   = 4'd1,
        S_CHECK  = 4'd2,
        S_SHIFT  = 4'd3,
        S_SUB    = 4'd4,
        S_WRITE  = 4'd5,
        S_RESULT = 4'd6,
        S_DONE   = 4'd7,
        S_ERROR  = 4'd8
    } state_t;

    // Slice control lines, forced low while scan is active.
    typedef struct packed {
        logic load_a;
        logic load_b;
        logic load_m;
        logic load_result;
        logic en_op1;
        logic en_op2;
        logic en_sub;
        logic en_zero;
        logic increment;
    } ctrl_t;

    // Host status lines, which keep their decoded value during scan.
    typedef struct packed {
        logic busy;
        logic done;
        logic div_zero;
    } status_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               borrow_q, borrow_d;
    ctrl_t              ctrl_q;
    status_t            status_q;
    ctrl_t              w_ctrl;

    function automatic ctrl_t decode_ctrl(input state_t s, input logic borrow);
        ctrl_t c;
        c = '0;
        case (s)
            S_LOAD: begin
                c.load_a  = 1'b1;
                c.load_b  = 1'b1;
                c.load_m  = 1'b1;
                c.en_zero = 1'b1;
            end
            S_CHECK: c.en_op2 = 1'b1;
            S_SHIFT: begin
                c.load_m = 1'b1;
                c.load_a = 1'b1;
                c.en_op1 = 1'b1;
            end
            S_SUB: begin
                c.en_op1 = 1'b1;
                c.en_op2 = 1'b1;
                c.en_sub = 1'b1;
            end
            S_WRITE: begin
                // Commit the difference and set the quotient bit only when
                // the trial subtract did not borrow; otherwise M keeps its
                // pre-subtract value, which restores it.
                if (borrow) begin
                    c.en_op1    = 1'b1;
                    c.en_op2    = 1'b1;
                    c.en_sub    = 1'b1;
                    c.load_m    = 1'b1;
                    c.increment = 1'b1;
                end
            end
            S_RESULT: c.load_result = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

    function automatic status_t decode_status(input state_t s);
        status_t st;
        st = '0;
        case (s)
            S_LOAD, S_CHECK, S_SHIFT, S_SUB, S_WRITE, S_RESULT: st.busy = 1'b1;
            S_DONE:  st.done = 1'b1;
            S_ERROR: begin
                st.done     = 1'b1;
                st.div_zero = 1'b1;
            end
            default: st = '0;
        endcase
        return st;
    endfunction

    // Next-state logic; scan holds every piece of state.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        borrow_d = borrow_q;
        if (!scan_enable_i) begin
            case (state_q)
                S_IDLE:  if (start_i) state_d = S_LOAD;
                S_LOAD:  state_d = S_CHECK;
                S_CHECK: begin
                    if (divisor_zero_i) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_SHIFT;
                        count_d = '0;
                    end
                end
                S_SHIFT: state_d = S_SUB;
                S_SUB: begin
                    borrow_d = n_borrow_out_i;
                    state_d  = S_WRITE;
                end
                S_WRITE: begin
                    if (count_q == CNT_W'(WIDTH - 1)) begin
                        state_d = S_RESULT;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                        state_d = S_SHIFT;
                    end
                end
                S_RESULT: state_d = S_DONE;
                S_DONE:   state_d = S_IDLE;
                S_ERROR:  state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they are registered yet
    // line up cycle-for-cycle with the state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            borrow_q <= 1'b0;
            ctrl_q   <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            borrow_q <= borrow_d;
            ctrl_q   <= decode_ctrl(state_d, borrow_d);
            status_q <= decode_status(state_d);
        end
    end

    // Scan is the only input allowed to reach outputs combinationally: it
    // drives test_o and silences the slice controls in the same cycle.
    assign w_ctrl = scan_enable_i ? ctrl_t'('0) : ctrl_q;

    assign load_a_o      = w_ctrl.load_a;
    assign load_b_o      = w_ctrl.load_b;
    assign load_m_o      = w_ctrl.load_m;
    assign load_result_o = w_ctrl.load_result;
    assign enable_op1_o  = w_ctrl.en_op1;
    assign enable_op2_o  = w_ctrl.en_op2;
    assign enable_sub_o  = w_ctrl.en_sub;
    assign enable_zero_o = w_ctrl.en_zero;
    assign increment_o   = w_ctrl.increment;

    assign busy_o        = status_q.busy;
    assign done_o        = status_q.done;
    assign div_zero_o    = status_q.div_zero;

    assign test_o        = scan_enable_i;
    assign n_borrow_in_o = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_divider_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_divider_sequencer
//  Purpose  : Self-checking bench for divider_sequencer. A behavioural
//             slice-array model responds to the control lines; a scoreboard
//             holds the expected completion cycle and results of each divide.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_divider_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic scan = 1'b0;
    logic n_borrow_out, divisor_zero;
    logic busy_o, done_o, div_zero_o, load_a_o, load_b_o, load_m_o;
    logic load_result_o, enable_op1_o, enable_op2_o, enable_sub_o;
    logic enable_zero_o, increment_o, n_borrow_in_o, test_o;

    divider_sequencer #(.WIDTH(8), .CNT_W(3)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .scan_enable_i  (scan),
        .n_borrow_out_i (n_borrow_out),
        .divisor_zero_i (divisor_zero),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .div_zero_o     (div_zero_o),
        .load_a_o       (load_a_o),
        .load_b_o       (load_b_o),
        .load_m_o       (load_m_o),
        .load_result_o  (load_result_o),
        .enable_op1_o   (enable_op1_o),
        .enable_op2_o   (enable_op2_o),
        .enable_sub_o   (enable_sub_o),
        .enable_zero_o  (enable_zero_o),
        .increment_o    (increment_o),
        .n_borrow_in_o  (n_borrow_in_o),
        .test_o         (test_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural slice-array model ----------------
    logic [7:0] op1 = '0, op2 = '0;
    logic [7:0] a_r = '0, b_r = '0, q_res = '0, r_res = '0;
    logic [8:0] m_r = '0;

    always @(posedge clk) begin
        if (load_a_o && load_b_o && enable_zero_o) begin
            a_r <= op1;
            b_r <= op2;
            m_r <= '0;
        end else if (load_m_o && load_a_o && enable_op1_o) begin
            m_r <= {m_r[7:0], a_r[7]};
            a_r <= {a_r[6:0], 1'b0};
        end else if (load_m_o && enable_sub_o) begin
            m_r <= m_r - {1'b0, b_r};
        end
        if (increment_o) a_r[0] <= 1'b1;
        if (load_result_o) begin
            q_res <= a_r;
            r_res <= m_r[7:0];
        end
    end

    assign n_borrow_out = (m_r >= {1'b0, b_r});
    assign divisor_zero = (b_r == 8'd0);

    // ---------------- scoreboard ----------------
    typedef struct {
        int         exp_cyc;
        logic       dz;
        logic [7:0] q;
        logic [7:0] r;
        int         incs;
        int         subs;
        int         lrs;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t make_exp(input logic [7:0] a, input logic [7:0] b, input int t0);
        exp_t e;
        e.dz = (b == 8'd0);
        if (e.dz) begin
            e.exp_cyc = t0 + 3;
            e.q = '0; e.r = '0;
            e.incs = 0; e.subs = 0; e.lrs = 0;
        end else begin
            e.exp_cyc = t0 + 28;
            e.q = a / b;
            e.r = a % b;
            e.incs = $countones(e.q);
            // one trial subtract per bit plus one commit per quotient one
            e.subs = 8 + $countones(e.q);
            e.lrs = 1;
        end
        return e;
    endfunction

    // ---------------- monitor ----------------
    int   inc_cnt = 0, sub_cnt = 0, lr_cnt = 0;
    logic prev_done = 1'b0;

    always @(negedge clk) begin
        #1;
        if (rst) begin
            inc_cnt = 0; sub_cnt = 0; lr_cnt = 0; prev_done = 1'b0;
        end else begin
            if (increment_o)   inc_cnt++;
            if (enable_sub_o)  sub_cnt++;
            if (load_result_o) lr_cnt++;
            if (div_zero_o && !done_o) chk("divzero_without_done", 1, 0);
            if (done_o) begin
                chk("done_single_cycle", int'(prev_done), 0);
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_cycle", cyc, e.exp_cyc);
                    chk("div_zero", int'(div_zero_o), int'(e.dz));
                    chk("increment_pulses", inc_cnt, e.incs);
                    chk("sub_cycles", sub_cnt, e.subs);
                    chk("load_result_pulses", lr_cnt, e.lrs);
                    if (!e.dz) begin
                        chk("quotient", int'(q_res), int'(e.q));
                        chk("remainder", int'(r_res), int'(e.r));
                    end
                end
                inc_cnt = 0; sub_cnt = 0; lr_cnt = 0;
            end
            prev_done = done_o;
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [13:0] out_vec();
        return {busy_o, done_o, div_zero_o, load_a_o, load_b_o, load_m_o,
                load_result_o, enable_op1_o, enable_op2_o, enable_sub_o,
                enable_zero_o, increment_o, n_borrow_in_o, test_o};
    endfunction

    function automatic logic [8:0] ctrl_vec();
        return {load_a_o, load_b_o, load_m_o, load_result_o, enable_op1_o,
                enable_op2_o, enable_sub_o, enable_zero_o, increment_o};
    endfunction

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy_o || done_o) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("idle_timeout", n, 0);
    endtask

    task automatic start_div(input logic [7:0] a, input logic [7:0] b,
                             input int extra, output int t0);
        exp_t e;
        wait_idle();
        op1   = a;
        op2   = b;
        start = 1'b1;
        t0    = cyc;
        e = make_exp(a, b, t0);
        e.exp_cyc += extra;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int t0;
        logic [7:0] ra, rb;

        repeat (3) @(negedge clk);
        chk("reset_outputs_held", int'(out_vec()), 14'b00000000000010);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("reset_outputs", int'(out_vec()), 14'b00000000000010);

        // directed divides
        start_div(8'd100, 8'd7, 0, t0);
        start_div(8'd255, 8'd1, 0, t0);
        start_div(8'd5,   8'd9, 0, t0);
        start_div(8'd77,  8'd0, 0, t0);
        start_div(8'd200, 8'd201, 0, t0);

        // Start pulses during a divide must be ignored
        start_div(8'd200, 8'd13, 0, t0);
        while (cyc != t0 + 5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc != t0 + 20) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // Start held high: second divide loads at T+30
        wait_idle();
        op1 = 8'd150; op2 = 8'd11;
        start = 1'b1;
        t0 = cyc;
        sb.push_back(make_exp(8'd150, 8'd11, t0));
        sb.push_back(make_exp(8'd150, 8'd11, t0 + 29));
        while (cyc != t0 + 29) @(negedge clk);
        chk("no_load_in_idle", int'(load_a_o), 0);
        @(negedge clk);
        chk("second_load", int'(load_a_o), 1);
        @(negedge clk);
        start = 1'b0;

        // asynchronous reset mid-divide
        start_div(8'd123, 8'd4, 0, t0);
        while (cyc != t0 + 12) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", int'(out_vec()), 14'b00000000000010);
        sb.delete();
        inc_cnt = 0; sub_cnt = 0; lr_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        start_div(8'd123, 8'd4, 0, t0);

        // scan freeze for 10 cycles starting in SUB of iteration 4
        start_div(8'd201, 8'd6, 10, t0);
        while (cyc != t0 + 16) @(negedge clk);
        chk("in_sub_before_scan", int'(ctrl_vec()), 9'b000011100);
        scan = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("scan_test", int'(test_o), 1);
            chk("scan_ctrl_zero", int'(ctrl_vec()), 0);
            chk("scan_busy_hold", int'({busy_o, done_o, n_borrow_in_o}), 3'b101);
            @(negedge clk);
        end
        scan = 1'b0;

        // randomized divides
        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom_range(0, 255));
            if (i % 7 == 3)      rb = 8'd0;
            else if (i % 2 == 1) rb = 8'($urandom_range(1, 15));
            else                 rb = 8'($urandom_range(1, 255));
            start_div(ra, rb, 0, t0);
        end

        begin
            int n = 0;
            while (sb.size() != 0 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/divider_sequencer.md
Name: divider_sequencer

Overview:
- Control FSM for the 8-slice restoring divider built from bitslice cells.
- Drives the shared per-slice control lines (Load*, Enable*, Increment, LoadResult, Test, nBorrowIn) to run one unsigned divide per Start.
- Samples the MSB-slice nBorrowOut and a divisor-zero flag, and reports Busy, Done and DivZero to the host.
- Sits between the host interface and the bitslice array; contains no datapath storage.

Parameters:
- WIDTH, 8, number of bitslices, which is also the number of quotient iterations.
- CNT_W, 3, iteration counter width; must satisfy 2**CNT_W >= WIDTH.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  request a divide; sampled only in IDLE.
- ScanEnable  input  1  scan mode: freezes the FSM and forwards to Test.
- nBorrowOut  input  1  MSB-slice borrow (active-low) from the trial subtract.
- DivisorZero  input  1  datapath flag, high when the B register is all zero.
- Busy  output  1  high from LOAD through RESULT.
- Done  output  1  one-cycle completion pulse.
- DivZero  output  1  one-cycle error pulse, coincident with Done.
- LoadA  output  1  to all slices.
- LoadB  output  1  to all slices.
- LoadM  output  1  to all slices.
- LoadResult  output  1  to all slices.
- EnableOp1  output  1  to all slices.
- EnableOp2  output  1  to all slices.
- EnableSub  output  1  to all slices.
- EnableZero  output  1  to all slices.
- Increment  output  1  to all slices.
- nBorrowIn  output  1  to the LSB slice.
- Test  output  1  to all slices.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, count=0, borrow_q=0. All outputs 0 except nBorrowIn=1.
- Control outputs are Moore-decoded from the state register; there are no combinational paths from inputs to outputs except ScanEnable->Test.
- Per-state outputs (anything not listed is 0; nBorrowIn=1 in every state):
  - IDLE: all control low. Start=1 -> LOAD.
  - LOAD: LoadA=1, LoadB=1, EnableZero=1, LoadM=1. This captures Operand1/Operand2 and clears M. -> CHECK.
  - CHECK: EnableOp2=1. If DivisorZero=1 -> ERROR, else -> SHIFT with count=0.
  - SHIFT: LoadM=1, LoadA=1, EnableOp1=1. Shifts M:A left one bit through the SDI/SDO chain. -> SUB.
  - SUB: EnableOp1=1, EnableOp2=1, EnableSub=1. borrow_q <= nBorrowOut at end of cycle. -> WRITE.
  - WRITE, case borrow_q=1 (M >= B): EnableOp1=1, EnableOp2=1, EnableSub=1, LoadM=1 (commit the difference), Increment=1 (quotient LSB set).
  - WRITE, case borrow_q=0: no loads; M is restored implicitly.
  - WRITE exit: if count==WIDTH-1 -> RESULT, else count<=count+1 and -> SHIFT.
  - RESULT: LoadResult=1. -> DONE.
  - DONE: Done=1. -> IDLE.
  - ERROR: Done=1, DivZero=1. -> IDLE.
- Busy=1 in LOAD, CHECK, SHIFT, SUB, WRITE and RESULT.
- Latency: Start sampled high in cycle T gives LOAD at T+1, CHECK at T+2, iterations at T+3..T+3*WIDTH+2, RESULT at T+3*WIDTH+3, Done at T+3*WIDTH+4. For WIDTH=8, Done is at T+28; a divide-by-zero gives Done/DivZero at T+3.
- Start while not in IDLE is ignored and not queued. Start held high across DONE starts the next divide in the cycle after returning to IDLE.
- A new Start is accepted in the cycle directly after Done, i.e. back-to-back operation with one IDLE cycle between divides.
- ScanEnable=1: state, count and borrow_q hold; Test=1; all other control outputs 0 (nBorrowIn stays 1); Done, DivZero and Busy hold their current decoded values. Deassertion resumes in the frozen state.
- Counter wrap: count never exceeds WIDTH-1; it is reset to 0 on entry to SHIFT from CHECK.
- Reset asserted mid-divide aborts immediately. No Done is produced, and the datapath contents are don't-care.

Test Plan:
- Reset, then Start with Operand1=100, Operand2=7 against a behavioural slice model -> Done exactly 28 cycles after Start; quotient 14, remainder 2; DivZero=0; Increment pulses exactly 3 times.
- Operand1=255, Operand2=1 -> Increment pulses 8 times, quotient 255, remainder 0. Operand1=5, Operand2=9 -> Increment never pulses, quotient 0, remainder 5.
- Operand2=0 -> Done and DivZero both high for exactly one cycle at T+3; SHIFT, SUB and LoadResult never asserted.
- Pulse Start at T+5 and T+20 during a divide -> ignored, single Done at T+28. Start held high continuously -> second LOAD at T+30.
- Assert Reset asynchronously between clock edges at T+12 -> all outputs return to reset values before the next edge; no Done; a fresh Start completes normally.
- ScanEnable high for 10 cycles starting in SUB at iteration 4 -> Test=1, controls 0, no state advance; after release, Done arrives 10 cycles later than nominal with a correct quotient.
